rwl_ctrl: RTL and testbench
===========================

RWL_CTRL -- requirements
Module: rwl_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default `ADDR_WIDTH, giving the number of read-address bits; word-line count N = 2**ADDR_WIDTH.
REQ-002 The block SHALL take parameter PRE_CYC, default 1, giving the precharge duration in clock cycles (legal range 1..15).
REQ-003 The block SHALL take parameter WL_CYC, default 2, giving the word-line assertion duration in clock cycles (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port rd_req, input, 1 bit: read request, sampled only in IDLE.
REQ-007 The block SHALL have port rd_addr, input, ADDR_WIDTH bits: row to read, latched on accept.
REQ-008 The block SHALL have port rwl, output, N bits: one-hot read word lines feeding the RWL buffer strip IN bus.
REQ-009 The block SHALL have port pre_en, output, 1 bit: bit-line precharge enable.
REQ-010 The block SHALL have port sense_en, output, 1 bit: sense-amp strobe.
REQ-011 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-012 The block SHALL have port rd_ack, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, WL, SENSE and DONE.
REQ-014 In IDLE, rd_req=1 at a clock edge SHALL latch rd_addr into addr_q and move to PRE; rd_req=0 SHALL keep the FSM in IDLE.
REQ-015 PRE SHALL last exactly PRE_CYC cycles with pre_en=1, then move to WL.
REQ-016 WL SHALL last exactly WL_CYC cycles with rwl = 1<<addr_q (exactly one bit high), then move to SENSE.
REQ-017 SENSE SHALL last 1 cycle with sense_en=1 and rwl=0, then move to DONE.
REQ-018 DONE SHALL last 1 cycle with rd_ack=1, then return to IDLE.
REQ-019 busy SHALL be 1 in PRE, WL, SENSE and DONE, and 0 in IDLE.
REQ-020 rd_req and rd_addr SHALL be ignored outside IDLE, with no queuing; a request held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-021 Latency from the accept edge to the rd_ack cycle SHALL be PRE_CYC+WL_CYC+2 cycles; the minimum back-to-back period SHALL be PRE_CYC+WL_CYC+3 cycles.
REQ-022 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-023 pre_en, rwl, sense_en and rd_ack SHALL be mutually exclusive (never active in the same cycle).
REQ-024 rwl SHALL be all-zero in every state except WL.
REQ-025 A single 4-bit down-counter SHALL time the PRE and WL states and SHALL be reloaded on each state entry.

Reset
REQ-026 While rst=1 at a clock edge, the next state SHALL be IDLE, with rwl=0, pre_en=0, sense_en=0, busy=0, rd_ack=0, addr_q=0 and counter=0.
REQ-027 Reset asserted mid-operation, including during WL, SHALL clear rwl and all strobes at that edge with no partial completion, and rd_ack SHALL not be issued.
REQ-028 rd_req asserted in the same cycle as rst SHALL be dropped.

Structure
REQ-029 ADDR_WIDTH SHALL come from the shared defines header used by the RWL buffer strip, and state encodings SHALL be localparams.
REQ-030 The one-hot decode SHALL be the sub-module rwl_decoder (inputs addr and en; output N-bit one-hot), instantiated once and registered at its output.

Verification
REQ-031 Bench scenario: reset, then rd_req=1 with rd_addr=0 for one cycle (defaults) -> pre_en high for 1 cycle; rwl=8'b0000_0001 for 2 cycles; sense_en for 1 cycle; rd_ack in cycle 5 after the accept edge.
REQ-032 Bench scenario: rd_addr=6 with rd_req held high for 20 cycles -> rwl=8'b0100_0000 per read; rd_ack every 6 cycles; busy low for exactly 1 cycle between reads.
REQ-033 Bench scenario: accept rd_addr=1, then change rd_addr to 7 during PRE -> rwl=8'b0000_0010, unaffected by the change.
REQ-034 Bench scenario: rst pulsed during the second WL cycle -> rwl=0 at the next edge; no rd_ack; busy=0; a new request is then accepted normally.
REQ-035 Bench scenario: PRE_CYC=3, WL_CYC=4, rd_addr=4 -> pre_en 3 cycles, rwl=8'b0001_0000 4 cycles, rd_ack at accept+9.
REQ-036 Bench scenario: every test -> assertion checks $onehot0(rwl) and mutual exclusion of strobes on every cycle.

Source files
------------

// File: rtl/rwl_ctrl_pkg.sv
// rwl_ctrl_pkg: state encodings and timer width shared by the read word-line controller.
package rwl_ctrl_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE = 3'd1;
    localparam logic [2:0] ST_WL = 3'd2;
    localparam logic [2:0] ST_SENSE = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam int CNT_W = 4;
    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PRE = ST_PRE,
        WL = ST_WL,
        SENSE = ST_SENSE,
        DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/rwl_decoder.sv
// rwl_decoder: address to one-hot word-line decode, all-zero when not enabled.
module rwl_decoder #(
    parameter int ADDR_WIDTH = 3,
    localparam int N = 2 ** ADDR_WIDTH
) (
    input logic [ADDR_WIDTH-1:0] addr,
    input logic en,
    output logic [N-1:0] onehot
);
    always_comb onehot = en ? N'(1) << addr : '0;
endmodule

// File: rtl/rwl_ctrl.sv
// rwl_ctrl: read sequencer driving precharge, one-hot word lines and sense strobe.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
module rwl_ctrl
    import rwl_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC = 2
) (
    input logic clk,
    input logic rst,
    input logic rd_req,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [2**ADDR_WIDTH-1:0] rwl,
    output logic pre_en,
    output logic sense_en,
    output logic busy,
    output logic rd_ack
);
    localparam int N = 2 ** ADDR_WIDTH;
    state_t st, nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [N-1:0] dec;
    always_comb begin
        nxt = st;
        cnt_n = cnt;
        addr_n = addr_q;
        case (st)
            IDLE: if (rd_req) begin
                nxt = PRE;
                addr_n = rd_addr;
                cnt_n = CNT_W'(PRE_CYC - 1);
            end
            PRE: if (cnt == '0) begin
                nxt = WL;
                cnt_n = CNT_W'(WL_CYC - 1);
            end else cnt_n = cnt - CNT_W'(1);
            WL: if (cnt == '0) begin
                nxt = SENSE;
                cnt_n = '0;
            end else cnt_n = cnt - CNT_W'(1);
            SENSE: nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they align with the state they describe.
    rwl_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
        .addr(addr_q),
        .en(nxt == WL),
        .onehot(dec)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            rwl <= '0;
            pre_en <= 1'b0;
            sense_en <= 1'b0;
            busy <= 1'b0;
            rd_ack <= 1'b0;
        end else begin
            st <= nxt;
            cnt <= cnt_n;
            addr_q <= addr_n;
            rwl <= dec;
            pre_en <= nxt == PRE;
            sense_en <= nxt == SENSE;
            busy <= nxt != IDLE;
            rd_ack <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_rwl_ctrl.sv
// tb_rwl_ctrl: directed and random read sequences against a phase-based reference model.
module tb_rwl_ctrl;
    logic clk = 1'b0, rst = 1'b1, rd_req = 1'b0, req2 = 1'b0;
    logic [2:0] rd_addr = '0, addr2 = '0;
    logic [7:0] rwl, rwl2;
    logic pre_en, sense_en, busy, rd_ack, pre_en2, sense_en2, busy2, rd_ack2;
    logic [11:0] o1, o2;
    int checks = 0, errors = 0;
    int ph1 = 0, ph2 = 0, ma1 = 0, ma2 = 0;

    always #5 clk = ~clk;

    rwl_ctrl #(.ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .rwl(rwl), .pre_en(pre_en), .sense_en(sense_en), .busy(busy), .rd_ack(rd_ack)
    );
    rwl_ctrl #(.ADDR_WIDTH(3), .PRE_CYC(3), .WL_CYC(4)) dut2 (
        .clk(clk), .rst(rst), .rd_req(req2), .rd_addr(addr2),
        .rwl(rwl2), .pre_en(pre_en2), .sense_en(sense_en2), .busy(busy2), .rd_ack(rd_ack2)
    );

    assign o1 = {rwl, pre_en, sense_en, busy, rd_ack};
    assign o2 = {rwl2, pre_en2, sense_en2, busy2, rd_ack2};

    // Reference: phase = cycles elapsed since the accept edge, 0 when idle.
    always @(posedge clk) begin
        if (rst) begin ph1 <= 0; ma1 <= 0; end
        else if (ph1 == 0) begin if (rd_req) begin ph1 <= 1; ma1 <= int'(rd_addr); end end
        else ph1 <= (ph1 == 1 + 2 + 2) ? 0 : ph1 + 1;
    end
    always @(posedge clk) begin
        if (rst) begin ph2 <= 0; ma2 <= 0; end
        else if (ph2 == 0) begin if (req2) begin ph2 <= 1; ma2 <= int'(addr2); end end
        else ph2 <= (ph2 == 3 + 4 + 2) ? 0 : ph2 + 1;
    end

    function automatic logic [11:0] mexp(int ph, int a, int p, int w);
        logic [7:0] r;
        r = (ph > p && ph <= p + w) ? 8'(1 << a) : 8'h0;
        return {r, (ph >= 1 && ph <= p), (ph == p + w + 1), (ph != 0), (ph == p + w + 2)};
    endfunction

    always @(negedge clk) begin
        checks += 4;
        if (!$onehot0(rwl)) begin errors++; $display("FAIL onehot0 dut1: rwl=%b", rwl); end
        if ($countones({pre_en, |rwl, sense_en, rd_ack}) > 1) begin errors++; $display("FAIL excl dut1: got %b need at most one", {pre_en, |rwl, sense_en, rd_ack}); end
        if (!$onehot0(rwl2)) begin errors++; $display("FAIL onehot0 dut2: rwl=%b", rwl2); end
        if ($countones({pre_en2, |rwl2, sense_en2, rd_ack2}) > 1) begin errors++; $display("FAIL excl dut2: got %b need at most one", {pre_en2, |rwl2, sense_en2, rd_ack2}); end
    end

    task automatic test_reset;
        rst = 1'b1; rd_req = 1'b1; rd_addr = 3'd5; req2 = 1'b1; addr2 = 3'd5;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o1 !== 12'h0 || o2 !== 12'h0) begin errors++; $display("FAIL reset: got %h/%h need 000/000", o1, o2); end
        end
        rst = 1'b0; rd_req = 1'b0; req2 = 1'b0;
        @(negedge clk);
        checks++;
        if (o1 !== 12'h0 || o2 !== 12'h0) begin errors++; $display("FAIL reset_drop: got %h/%h need 000/000", o1, o2); end
    endtask

    task automatic test_single;
        rd_req = 1'b1; rd_addr = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            rd_req = 1'b0;
            checks++;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL single c%0d: got %h need %h", i, o1, mexp(ph1, ma1, 1, 2)); end
            if (i == 2 || i == 3) begin
                checks++;
                if (rwl !== 8'b0000_0001) begin errors++; $display("FAIL single_rwl c%0d: got %b need 00000001", i, rwl); end
            end
            if (i == 5) begin
                checks++;
                if (rd_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b need 1", rd_ack); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int last = -1, acks = 0, low = 0;
        rd_req = 1'b1; rd_addr = 3'd6;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL b2b c%0d: got %h need %h", i, o1, mexp(ph1, ma1, 1, 2)); end
            if (rwl !== 8'h0) begin
                checks++;
                if (rwl !== 8'b0100_0000) begin errors++; $display("FAIL b2b_rwl c%0d: got %b need 01000000", i, rwl); end
            end
            if (rd_ack === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != 6) begin errors++; $display("FAIL b2b_period: got %0d need 6", i - last); end
                end
                last = i; acks++;
            end
            if (busy !== 1'b1) low++;
            else if (low > 0) begin
                checks++;
                if (low != 1) begin errors++; $display("FAIL b2b_gap: got %0d need 1", low); end
                low = 0;
            end
        end
        checks++;
        if (acks != 3) begin errors++; $display("FAIL b2b_acks: got %0d need 3", acks); end
        rd_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL b2b_drain: got %h need %h", o1, mexp(ph1, ma1, 1, 2)); end
        end
    endtask

    task automatic test_addr_change;
        rd_req = 1'b1; rd_addr = 3'd1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            rd_req = 1'b0;
            if (i == 1) rd_addr = 3'd7;
            checks++;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL addr_chg c%0d: got %h need %h", i, o1, mexp(ph1, ma1, 1, 2)); end
            if (i == 2 || i == 3) begin
                checks++;
                if (rwl !== 8'b0000_0010) begin errors++; $display("FAIL addr_chg_rwl c%0d: got %b need 00000010", i, rwl); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0, acks = 0;
        rd_req = 1'b1; rd_addr = 3'($urandom_range(0, 7));
        do begin
            @(negedge clk);
            rd_req = 1'b0;
            n++;
        end while (ph1 != 3 && n < 10);
        checks++;
        if (n >= 10) begin errors++; $display("FAIL rst_mid_timeout: got %0d cycles need < 10", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (o1 !== 12'h0) begin errors++; $display("FAIL rst_mid: got %h need 000", o1); end
        repeat (5) begin
            @(negedge clk);
            if (rd_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got acks=%0d busy=%b need 0/0", acks, busy); end
        rd_req = 1'b1; rd_addr = 3'd2;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            rd_req = 1'b0;
            if (rd_ack === 1'b1) acks++;
            checks++;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL rst_mid_new c%0d: got %h need %h", i, o1, mexp(ph1, ma1, 1, 2)); end
        end
        checks++;
        if (acks != 1) begin errors++; $display("FAIL rst_mid_new_ack: got %0d need 1", acks); end
    endtask

    task automatic test_params;
        req2 = 1'b1; addr2 = 3'd4;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            req2 = 1'b0;
            checks++;
            if (o2 !== mexp(ph2, ma2, 3, 4)) begin errors++; $display("FAIL params c%0d: got %h need %h", i, o2, mexp(ph2, ma2, 3, 4)); end
            if (i >= 4 && i <= 7) begin
                checks++;
                if (rwl2 !== 8'b0001_0000) begin errors++; $display("FAIL params_rwl c%0d: got %b need 00010000", i, rwl2); end
            end
            if (i == 9) begin
                checks++;
                if (rd_ack2 !== 1'b1) begin errors++; $display("FAIL params_ack: got %b need 1", rd_ack2); end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks += 2;
            if (o1 !== mexp(ph1, ma1, 1, 2)) begin errors++; $display("FAIL rand1 c%0d: got %h need %h", i, o1, mexp(ph1, ma1, 1, 2)); end
            if (o2 !== mexp(ph2, ma2, 3, 4)) begin errors++; $display("FAIL rand2 c%0d: got %h need %h", i, o2, mexp(ph2, ma2, 3, 4)); end
            rst = ($urandom_range(0, 40) == 0);
            rd_req = ($urandom_range(0, 2) != 0);
            rd_addr = 3'($urandom);
            req2 = ($urandom_range(0, 2) != 0);
            addr2 = 3'($urandom);
        end
        rst = 1'b0; rd_req = 1'b0; req2 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_addr_change;
        test_reset_mid;
        test_params;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
